branch_ctrl: RTL and testbench

Branch resolution and control unit for the LEGv8 datapath. Decodes the fetched instruction, holds the NZCV flags register, and evaluates branch conditions. It produces the `uncond_br`, `br_taken`, `pc_rd`, `cond_addr19` and `uncond_addr26` controls consumed by the program counter, plus the BL link-register write. It also runs a squash FSM that flushes a configurable number of wrong-path instructions after every redirect.

---
 rtl/branch_ctrl_if.sv | 43 ++++
 rtl/branch_ctrl.sv | 152 +++++++++++++++
 tb/tb_branch_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_ctrl_if.sv
// ============================================================================
// Module   : branch_ctrl_if
// Brief    : Instruction / control bundle between the fetch-decode stage and
//            the branch resolution unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_ctrl_if #(
    parameter int CNT_WIDTH = 16
);
    logic [31:0]          i_instr;
    logic                 i_instr_valid;
    logic [3:0]           i_alu_flags;
    logic                 i_flag_we;
    logic                 i_rt_zero;
    logic [63:0]          i_pc_4in;

    logic                 o_uncond_br;
    logic                 o_br_taken;
    logic                 o_pc_rd;
    logic [18:0]          o_cond_addr19;
    logic [25:0]          o_uncond_addr26;
    logic                 o_link_we;
    logic [63:0]          o_link_data;
    logic [3:0]           o_flags;
    logic                 o_flush;
    logic [CNT_WIDTH-1:0] o_br_count;

    modport slave (
        input  i_instr, i_instr_valid, i_alu_flags, i_flag_we, i_rt_zero, i_pc_4in,
        output o_uncond_br, o_br_taken, o_pc_rd, o_cond_addr19, o_uncond_addr26,
               o_link_we, o_link_data, o_flags, o_flush, o_br_count
    );

    modport master (
        output i_instr, i_instr_valid, i_alu_flags, i_flag_we, i_rt_zero, i_pc_4in,
        input  o_uncond_br, o_br_taken, o_pc_rd, o_cond_addr19, o_uncond_addr26,
               o_link_we, o_link_data, o_flags, o_flush, o_br_count
    );
endinterface

`default_nettype wire

// File: rtl/branch_ctrl.sv
// ============================================================================
// Module   : branch_ctrl
// Brief    : LEGv8 branch decode, NZCV flags register, condition evaluation,
//            redirect counter and wrong-path squash FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  wire logic      clk,
    input  wire logic      reset,
    branch_ctrl_if.slave   bus
);

    localparam int FC_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int c_SQ_LOAD = (FLUSH_CYCLES > 0) ? (FLUSH_CYCLES - 1) : 0;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [FC_W-1:0]      r_sq_cnt;
    logic [FC_W-1:0]      w_sq_cnt_nxt;
    logic [3:0]           r_flags;
    logic [CNT_WIDTH-1:0] r_br_count;

    logic w_act;
    logic w_is_b;
    logic w_is_bl;
    logic w_is_bcond;
    logic w_is_cbz;
    logic w_is_cbnz;
    logic w_is_br;
    logic w_cond;
    logic w_taken;
    logic w_pc_rd;
    logic w_redirect;
    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    // Reset is folded in so every control output is low while it is asserted.
    assign w_act = bus.i_instr_valid & (r_state == ST_RUN) & reset;

    assign w_is_b     = (bus.i_instr[31:26] == 6'b000101);
    assign w_is_bl    = (bus.i_instr[31:26] == 6'b100101);
    assign w_is_bcond = (bus.i_instr[31:24] == 8'b01010100);
    assign w_is_cbz   = (bus.i_instr[31:24] == 8'b10110100);
    assign w_is_cbnz  = (bus.i_instr[31:24] == 8'b10110101);
    assign w_is_br    = (bus.i_instr[31:21] == 11'b11010110000);

    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        w_cond = 1'b1;
        case (bus.i_instr[3:0])
            4'h0:    w_cond = w_z;
            4'h1:    w_cond = ~w_z;
            4'h2:    w_cond = w_c;
            4'h3:    w_cond = ~w_c;
            4'h4:    w_cond = w_n;
            4'h5:    w_cond = ~w_n;
            4'h6:    w_cond = w_v;
            4'h7:    w_cond = ~w_v;
            4'h8:    w_cond = w_c & ~w_z;
            4'h9:    w_cond = ~w_c | w_z;
            4'hA:    w_cond = (w_n == w_v);
            4'hB:    w_cond = (w_n != w_v);
            4'hC:    w_cond = ~w_z & (w_n == w_v);
            4'hD:    w_cond = w_z | (w_n != w_v);
            default: w_cond = 1'b1;
        endcase
    end

    assign w_taken = w_act & (w_is_b | w_is_bl | (w_is_bcond & w_cond) |
                              (w_is_cbz & bus.i_rt_zero) | (w_is_cbnz & ~bus.i_rt_zero));
    assign w_pc_rd    = w_act & w_is_br;
    assign w_redirect = w_taken | w_pc_rd;

    assign bus.o_uncond_br     = w_act & (w_is_b | w_is_bl);
    assign bus.o_br_taken      = w_taken;
    assign bus.o_pc_rd         = w_pc_rd;
    assign bus.o_link_we       = w_act & w_is_bl;
    assign bus.o_cond_addr19   = bus.i_instr[23:5];
    assign bus.o_uncond_addr26 = bus.i_instr[25:0];
    assign bus.o_link_data     = bus.i_pc_4in;
    assign bus.o_flags         = r_flags;
    assign bus.o_flush         = (r_state == ST_FLUSH);
    assign bus.o_br_count      = r_br_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= 4'b0000;
        end else if (w_act & bus.i_flag_we) begin
            r_flags <= bus.i_alu_flags;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_br_count <= '0;
        end else if (w_redirect && (r_br_count != {CNT_WIDTH{1'b1}})) begin
            r_br_count <= r_br_count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_RUN;
            r_sq_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sq_cnt <= w_sq_cnt_nxt;
        end
    end

    // The squash counter holds the number of flush cycles still owed after
    // the current one, so it loads FLUSH_CYCLES-1 on entry.
    always_comb begin
        w_state_nxt  = r_state;
        w_sq_cnt_nxt = r_sq_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_redirect && (FLUSH_CYCLES > 0)) begin
                    w_state_nxt  = ST_FLUSH;
                    w_sq_cnt_nxt = FC_W'(c_SQ_LOAD);
                end
            end
            ST_FLUSH: begin
                if (r_sq_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_sq_cnt_nxt = r_sq_cnt - FC_W'(1);
                end
            end
            default: begin
                w_state_nxt  = ST_RUN;
                w_sq_cnt_nxt = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
// ============================================================================
// Module   : tb_branch_ctrl
// Brief    : Three branch_ctrl configurations (1/16, 2/16, 0/2) driven with a
//            shared stimulus and compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic [2:0]  rst_n;
    logic [31:0] instr;
    logic        valid;
    logic [3:0]  aflags;
    logic        fwe;
    logic        rtz;
    logic [63:0] pc4;

    logic [2:0]  o_ub, o_bt, o_pr, o_lw, o_fl;
    logic [3:0]  o_flg [3];
    logic [15:0] o_cnt [3];
    logic [18:0] o_a19 [3];
    logic [25:0] o_a26 [3];
    logic [63:0] o_ld  [3];

    int n_checks = 0;
    int n_err    = 0;

    logic [3:0] m_flags [3];
    int         m_rem   [3];
    int         m_cnt   [3];
    int         fcv     [3] = '{1, 2, 0};
    int         cmax    [3] = '{65535, 65535, 3};

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int FC = (k == 0) ? 1 : ((k == 1) ? 2 : 0);
        localparam int CW = (k == 2) ? 2 : 16;
        branch_ctrl_if #(.CNT_WIDTH(CW)) bi ();
        assign bi.i_instr       = instr;
        assign bi.i_instr_valid = valid;
        assign bi.i_alu_flags   = aflags;
        assign bi.i_flag_we     = fwe;
        assign bi.i_rt_zero     = rtz;
        assign bi.i_pc_4in      = pc4;
        assign o_ub[k]  = bi.o_uncond_br;
        assign o_bt[k]  = bi.o_br_taken;
        assign o_pr[k]  = bi.o_pc_rd;
        assign o_lw[k]  = bi.o_link_we;
        assign o_fl[k]  = bi.o_flush;
        assign o_flg[k] = bi.o_flags;
        assign o_cnt[k] = 16'(bi.o_br_count);
        assign o_a19[k] = bi.o_cond_addr19;
        assign o_a26[k] = bi.o_uncond_addr26;
        assign o_ld[k]  = bi.o_link_data;
        branch_ctrl #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) u_dut (
            .clk   (clk),
            .reset (rst_n[k]),
            .bus   (bi.slave)
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_ctl(input int k, output logic ub, output logic bt,
                             output logic pr, output logic lw);
        logic act, b, bl, bc, cz, cn, br;
        act = valid && rst_n[k] && (m_rem[k] == 0);
        b   = (instr[31:26] == 6'b000101);
        bl  = (instr[31:26] == 6'b100101);
        bc  = (instr[31:24] == 8'h54);
        cz  = (instr[31:24] == 8'hB4);
        cn  = (instr[31:24] == 8'hB5);
        br  = (instr[31:21] == 11'b11010110000);
        ub  = act && (b || bl);
        bt  = act && (b || bl || (bc && cond_ok(instr[3:0], m_flags[k])) ||
                      (cz && rtz) || (cn && !rtz));
        pr  = act && br;
        lw  = act && bl;
    endtask

    task automatic model_reset(input int k);
        m_flags[k] = 4'b0000;
        m_rem[k]   = 0;
        m_cnt[k]   = 0;
    endtask

    task automatic check_all();
        logic ub, bt, pr, lw;
        for (int k = 0; k < 3; k++) begin
            model_ctl(k, ub, bt, pr, lw);
            check($sformatf("uncond_br[%0d]", k), 64'(o_ub[k]), 64'(ub));
            check($sformatf("br_taken[%0d]", k),  64'(o_bt[k]), 64'(bt));
            check($sformatf("pc_rd[%0d]", k),     64'(o_pr[k]), 64'(pr));
            check($sformatf("link_we[%0d]", k),   64'(o_lw[k]), 64'(lw));
            check($sformatf("flush[%0d]", k),     64'(o_fl[k]), 64'(m_rem[k] > 0));
            check($sformatf("flags[%0d]", k),     64'(o_flg[k]), 64'(m_flags[k]));
            check($sformatf("br_count[%0d]", k),  64'(o_cnt[k]), 64'(m_cnt[k]));
            check($sformatf("addr19[%0d]", k),    64'(o_a19[k]), 64'(instr[23:5]));
            check($sformatf("addr26[%0d]", k),    64'(o_a26[k]), 64'(instr[25:0]));
            check($sformatf("link_data[%0d]", k), o_ld[k], pc4);
        end
    endtask

    // Advance the model across one rising edge, using the inputs held there.
    task automatic model_edge();
        logic ub, bt, pr, lw, redirect;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n[k]) begin
                model_reset(k);
            end else begin
                model_ctl(k, ub, bt, pr, lw);
                redirect = bt || pr;
                if (valid && m_rem[k] == 0 && fwe) m_flags[k] = aflags;
                if (redirect && m_cnt[k] < cmax[k]) m_cnt[k]++;
                if (m_rem[k] > 0)                    m_rem[k]--;
                else if (redirect && fcv[k] > 0)     m_rem[k] = fcv[k];
            end
        end
    endtask

    task automatic drive(input logic [31:0] in, input logic v, input logic [3:0] af,
                         input logic we, input logic rz, input logic [63:0] p);
        instr = in; valid = v; aflags = af; fwe = we; rtz = rz; pc4 = p;
    endtask

    task automatic sample();
        @(negedge clk);
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cyc(input logic [31:0] in, input logic v, input logic [3:0] af,
                       input logic we, input logic rz, input logic [63:0] p);
        drive(in, v, af, we, rz, p);
        sample();
        tick();
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cyc(32'hD503201F, 1'b1, 4'hF, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic assert_reset(input int k);
        rst_n[k] = 1'b0;
        #1;
        model_reset(k);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0:       return {6'b000101, r[25:0]};
            1:       return {6'b100101, r[25:0]};
            2, 3:    return {8'h54, r[23:0]};
            4:       return {8'hB4, r[23:0]};
            5:       return {8'hB5, r[23:0]};
            6:       return {11'b11010110000, r[20:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        int cnt_before;
        int seq [5] = '{1, 2, 3, 3, 3};
        int rk;
        rst_n = 3'b000;
        drive(32'h14000148, 1'b1, 4'hF, 1'b1, 1'b0, 64'h100);
        for (int k = 0; k < 3; k++) model_reset(k);
        repeat (2) @(posedge clk);
        #1;
        cyc(32'h14000148, 1'b1, 4'hF, 1'b1, 1'b0, 64'h100);
        rst_n = 3'b111;

        // B #328 straight out of reset
        drive(32'h14000148, 1'b1, 4'h0, 1'b0, 1'b0, 64'h100);
        sample();
        check("b328_uncond", 64'(o_ub[0]), 64'd1);
        check("b328_taken",  64'(o_bt[0]), 64'd1);
        check("b328_addr26", 64'(o_a26[0]), 64'd328);
        tick();
        drive(32'hD503201F, 1'b1, 4'h0, 1'b0, 1'b0, 64'h0);
        sample();
        check("b328_flush", 64'(o_fl[0]), 64'd1);
        check("b328_count", 64'(o_cnt[0]), 64'd1);
        tick();
        nops(2);

        // SUBS setting Z, then B.EQ / B.NE
        cyc(32'hEB020020, 1'b1, 4'b0100, 1'b1, 1'b0, 64'h0);
        drive(32'h54001480, 1'b1, 4'b1011, 1'b0, 1'b0, 64'h0);
        sample();
        check("beq_flags",  64'(o_flg[0]), 64'h4);
        check("beq_taken",  64'(o_bt[0]), 64'd1);
        check("beq_uncond", 64'(o_ub[0]), 64'd0);
        check("beq_addr19", 64'(o_a19[0]), 64'd164);
        tick();
        nops(2);
        drive(32'h54001481, 1'b1, 4'b0000, 1'b0, 1'b0, 64'h0);
        sample();
        check("bne_taken", 64'(o_bt[0]), 64'd0);
        tick();

        // BL #8
        drive(32'h94000002, 1'b1, 4'h0, 1'b0, 1'b0, 64'h88);
        sample();
        check("bl_link_we", 64'(o_lw[0]), 64'd1);
        check("bl_link",    o_ld[0], 64'h88);
        check("bl_taken",   64'(o_bt[0]), 64'd1);
        check("bl_uncond",  64'(o_ub[0]), 64'd1);
        tick();
        nops(2);

        // BR, CBZ, CBNZ
        drive(32'hD61F00A0, 1'b1, 4'h0, 1'b0, 1'b0, 64'h0);
        sample();
        check("br_pc_rd", 64'(o_pr[0]), 64'd1);
        check("br_taken", 64'(o_bt[0]), 64'd0);
        tick();
        nops(2);
        for (int j = 0; j < 4; j++) begin
            drive((j < 2) ? 32'hB4000045 : 32'hB5000045, 1'b1, 4'h0, 1'b0, j[0], 64'h0);
            sample();
            check($sformatf("cb_taken%0d", j), 64'(o_bt[0]), 64'((j < 2) ? (j == 1) : (j == 2)));
            tick();
            nops(2);
        end

        // Two-cycle squash on instance 1, then reset in the middle of FLUSH
        cnt_before = m_cnt[1] + 1;
        cyc(32'h14000010, 1'b1, 4'h0, 1'b0, 1'b0, 64'h0);
        for (int j = 0; j < 2; j++) begin
            drive(32'h14000020, 1'b1, 4'h0, 1'b0, 1'b0, 64'h0);
            sample();
            check("sq_taken",  64'(o_bt[1]), 64'd0);
            check("sq_uncond", 64'(o_ub[1]), 64'd0);
            check("sq_count",  64'(o_cnt[1]), 64'(cnt_before));
            tick();
        end
        drive(32'h14000030, 1'b1, 4'h0, 1'b0, 1'b0, 64'h0);
        sample();
        check("sq_third", 64'(o_bt[1]), 64'd1);
        tick();
        assert_reset(1);
        check("rst_flush", 64'(o_fl[1]), 64'd0);
        cyc(32'h14000030, 1'b1, 4'h0, 1'b0, 1'b0, 64'h0);
        rst_n[1] = 1'b1;
        nops(2);

        // Saturating counter on the 2-bit, no-squash instance
        assert_reset(2);
        cyc(32'hD503201F, 1'b1, 4'h0, 1'b0, 1'b0, 64'h0);
        rst_n[2] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cyc(32'h14000004, 1'b1, 4'h0, 1'b0, 1'b0, 64'h0);
            check($sformatf("sat_count%0d", j), 64'(o_cnt[2]), 64'(seq[j]));
        end

        // Randomized traffic with occasional per-instance resets
        for (int i = 0; i < 600; i++) begin
            rk = -1;
            if ($urandom_range(0, 63) == 0) begin
                rk = int'($urandom_range(0, 2));
                assert_reset(rk);
            end
            cyc(rand_instr(), $urandom_range(0, 7) != 0, 4'($urandom), 1'($urandom),
                1'($urandom), {$urandom, $urandom});
            if (rk >= 0) rst_n[rk] = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
